ov_pix_packer: RTL and testbench
================================

OV_PIX_PACKER -- requirements
Module: ov_pix_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning word FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock (camera pixel clock domain); every register is clocked on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cam_vsync_i  input  1  frame blanking, high between frames.
REQ-005 SHALL have port cam_href_i  input  1  line-valid qualifier; one byte per cycle while high.
REQ-006 SHALL have port cam_data_i  input  8  pixel byte.
REQ-007 SHALL have port valid_o  output  1  packed word available; held high until accepted.
REQ-008 SHALL have port data_o  output  32  packed word; stable while valid_o is high.
REQ-009 SHALL have port ready_i  input  1  single-cycle acceptance pulse from the CDC handshake stage.
REQ-010 SHALL have port overflow_o  output  1  sticky flag: a completed word was dropped.

Function
REQ-011 SHALL register cam_vsync_i, cam_href_i and cam_data_i in one input stage; all further logic uses the registered copies.
REQ-012 SHALL keep a 2-bit byte index; each registered byte with href=1 and vsync=0 goes into lane [8*idx+7 : 8*idx], so the first byte of a word lands in [7:0].
REQ-013 SHALL clear the byte index and discard any partial word whenever registered href=0 or registered vsync=1.
REQ-014 SHALL write the word into the FIFO on the cycle after the byte with idx=3 is stored.
REQ-015 SHALL accept a FIFO write when occupancy < FIFO_DEPTH, or when occupancy == FIFO_DEPTH and a pop occurs in the same cycle; otherwise it SHALL drop the word and set overflow_o on the next edge.
REQ-016 SHALL clear overflow_o on the cycle after a registered-vsync rising edge; if a drop and a clear coincide, set SHALL win.
REQ-017 SHALL drive the output through a 3-state FSM: IDLE, PRESENT, GAP.
REQ-018 IDLE: if the FIFO is non-empty, it SHALL pop the head into data_o, set valid_o=1 and go to PRESENT; otherwise it SHALL stay in IDLE.
REQ-019 PRESENT: on ready_i=1 it SHALL clear valid_o and go to GAP; otherwise it SHALL hold data_o and valid_o.
REQ-020 GAP: it SHALL go to IDLE unconditionally, guaranteeing at least one cycle of valid_o=0 between words.
REQ-021 SHALL ignore ready_i outside PRESENT.
REQ-022 Latency: if the FIFO is empty and the FSM is in IDLE, valid_o SHALL rise 3 clk edges after the edge that samples the 4th byte at cam_data_i.
REQ-023 A vsync edge SHALL NOT flush the FIFO or the output word; completed words always drain.

Reset
REQ-024 Reset SHALL asynchronously force: valid_o=0, data_o=0, overflow_o=0, FSM=IDLE, FIFO empty, byte index=0, input registers=0.
REQ-025 Reset asserted mid-word or mid-handshake SHALL discard all held data; after release, operation SHALL restart from REQ-012 with the next href-high byte.

Configuration
REQ-026 With macro OV_PACKER_DROP_CNT_EN defined, the block SHALL add output drop_cnt_o (16 bits), which increments once per dropped word, saturates at 0xFFFF, clears on reset only, and is 0 after reset.
REQ-027 Without OV_PACKER_DROP_CNT_EN, drop_cnt_o and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-028 Send one line of 8 bytes 0x01..0x08 with ready_i pulsed 2 cycles after each valid_o rise -> words 0x04030201 then 0x08070605 appear, with valid_o low for 1 cycle after each ready_i pulse.
REQ-029 Send a line of 6 bytes 0xA0..0xA5 -> exactly one word 0xA3A2A1A0 appears; bytes 0xA4 and 0xA5 are discarded, and the next line starts at lane 0.
REQ-030 With FIFO_DEPTH=4 and ready_i held 0, send 24 bytes -> 5 words are retained (4 in the FIFO, 1 in data_o), overflow_o=1, and drop_cnt_o=1 when the macro is defined.
REQ-031 From the REQ-030 state, pulse vsync -> overflow_o clears the cycle after the registered rising edge; then pulse ready_i 5 times -> all 5 retained words drain in order.
REQ-032 Assert reset while valid_o=1 in PRESENT -> valid_o=0 immediately (asynchronously); after release, the first new 4 bytes yield a word with latency 3 per REQ-022.

Source files
------------

// File: rtl/ov_pix_packer.sv
// Camera byte stream to 32-bit word packer with word FIFO and valid/ready output.
// Define OV_PACKER_DROP_CNT_EN to add the 16-bit saturating drop counter drop_cnt_o.
module ov_pix_packer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cam_vsync_i,
    input  logic        cam_href_i,
    input  logic [7:0]  cam_data_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    input  logic        ready_i,
`ifdef OV_PACKER_DROP_CNT_EN
    output logic [15:0] drop_cnt_o,
    output logic        overflow_o
`else
    output logic        overflow_o
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } state_t;

    logic          vs_q;
    logic          vs_prev_q;
    logic          hr_q;
    logic [7:0]    dat_q;

    logic [1:0]    idx_q;
    logic [1:0]    idx_d;
    logic [31:0]   word_q;
    logic [31:0]   word_d;
    logic          wr_pend_q;
    logic          wr_pend_d;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;

    logic          push;
    logic          pop;
    logic          drop;
    logic          vs_rise;
    logic          ovf_q;
    logic          ovf_d;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   data_q;
    logic [31:0]   data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            hr_q      <= 1'b0;
            dat_q     <= 8'h00;
        end else begin
            vs_q      <= cam_vsync_i;
            vs_prev_q <= vs_q;
            hr_q      <= cam_href_i;
            dat_q     <= cam_data_i;
        end
    end

    // A finished word is flagged here and pushed one cycle later.
    always_comb begin
        idx_d     = idx_q;
        word_d    = word_q;
        wr_pend_d = 1'b0;
        if (hr_q && !vs_q) begin
            word_d[{idx_q, 3'b000} +: 8] = dat_q;
            idx_d     = idx_q + 2'd1;
            wr_pend_d = (idx_q == 2'd3);
        end else begin
            idx_d = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= 2'd0;
            word_q    <= 32'h0;
            wr_pend_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            word_q    <= word_d;
            wr_pend_q <= wr_pend_d;
        end
    end

    assign pop     = (state_q == IDLE) && (cnt_q != '0);
    assign push    = wr_pend_q && ((cnt_q < DEPTH_C) || pop);
    assign drop    = wr_pend_q && !push;
    assign vs_rise = vs_q && !vs_prev_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // A drop in the same cycle as a vsync clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (vs_rise) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    data_d  = mem_q[rd_ptr_q];
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ready_i) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o    = (state_q == PRESENT);
    assign data_o     = data_q;
    assign overflow_o = ovf_q;

`ifdef OV_PACKER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 16'h0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ov_pix_packer.sv
// Self-checking bench for ov_pix_packer: directed scenarios plus random lines
// checked against a byte-queue reference model.
module tb_ov_pix_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cam_vsync_i;
    logic        cam_href_i;
    logic [7:0]  cam_data_i;
    logic        valid_o;
    logic [31:0] data_o;
    logic        ready_i;
    logic        overflow_o;
`ifdef OV_PACKER_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    bit auto_rdy;
    int vcnt;
    logic [31:0] got[$];
    logic [31:0] exp_w[$];
    logic [7:0]  q[$];
    logic [31:0] w;

    always #5 clk = ~clk;

    ov_pix_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .cam_vsync_i(cam_vsync_i),
        .cam_href_i (cam_href_i),
        .cam_data_i (cam_data_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready_i),
`ifdef OV_PACKER_DROP_CNT_EN
        .drop_cnt_o (drop_cnt_o),
`endif
        .overflow_o (overflow_o)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock; records handshakes and runs the ready responder.
    task automatic tick();
        logic        hs;
        logic [31:0] hw;
        hs = valid_o && ready_i;
        hw = data_o;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        if (hs) begin
            got.push_back(hw);
            check("gap_after_ready", {31'b0, valid_o}, 32'd0);
        end
        if (valid_o) vcnt++;
        else vcnt = 0;
        if (auto_rdy && vcnt == 2) ready_i = 1'b1;
    endtask

    // Reference: only complete groups of four bytes form words, first byte low.
    function automatic void model_line(input logic [7:0] b[$]);
        for (int i = 0; i + 3 < b.size(); i += 4)
            exp_w.push_back({b[i+3], b[i+2], b[i+1], b[i]});
    endfunction

    task automatic send_line(input logic [7:0] b[$]);
        foreach (b[i]) begin
            cam_href_i = 1'b1;
            cam_data_i = b[i];
            tick();
        end
        cam_href_i = 1'b0;
        cam_data_i = 8'h00;
        tick();
        model_line(b);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (got.size() < exp_w.size() && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_count"}, 32'(got.size()), 32'(exp_w.size()));
        foreach (exp_w[i])
            if (i < got.size()) check(tag, got[i], exp_w[i]);
        got.delete();
        exp_w.delete();
    endtask

    task automatic latency(input string tag, input logic [31:0] wd);
        int n;
        for (int i = 0; i < 4; i++) begin
            cam_href_i = 1'b1;
            cam_data_i = wd[8*i +: 8];
            tick();
        end
        cam_href_i = 1'b0;
        cam_data_i = 8'h00;
        n = 0;
        while (!valid_o && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd3);
        check({tag, "_word"}, data_o, wd);
        exp_w.push_back(wd);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        cam_vsync_i = 1'b0;
        cam_href_i  = 1'b0;
        cam_data_i  = 8'h00;
        ready_i     = 1'b0;
        auto_rdy    = 1'b0;
        vcnt        = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'b0, valid_o}, 32'd0);
        check("reset_data", data_o, 32'd0);
        check("reset_ovf", {31'b0, overflow_o}, 32'd0);
`ifdef OV_PACKER_DROP_CNT_EN
        check("reset_dropcnt", {16'b0, drop_cnt_o}, 32'd0);
`endif
        reset = 1'b0;
        tick();

        latency("first", 32'h11223344);
        auto_rdy = 1'b1;
        vcnt = 0;
        drain("first");

        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(8'(i + 1));
        send_line(q);
        drain("line8");

        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'(8'hA0 + i));
        send_line(q);
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        send_line(q);
        drain("short_line");

        for (int l = 0; l < 6; l++) begin
            q.delete();
            for (int i = 0; i < $urandom_range(0, 13); i++)
                q.push_back(8'($urandom));
            send_line(q);
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 1) == 1) begin
                cam_vsync_i = 1'b1;
                tick();
                cam_vsync_i = 1'b0;
            end
        end
        drain("random");
        check("random_no_ovf", {31'b0, overflow_o}, 32'd0);

        auto_rdy = 1'b0;
        repeat (3) tick();
        q.delete();
        for (int i = 0; i < 24; i++) q.push_back(8'($urandom));
        send_line(q);
        while (exp_w.size() > DEPTH + 1) void'(exp_w.pop_back());
        repeat (4) tick();
        check("hold_valid", {31'b0, valid_o}, 32'd1);
        check("hold_data", data_o, exp_w[0]);
        check("overflow_set", {31'b0, overflow_o}, 32'd1);
`ifdef OV_PACKER_DROP_CNT_EN
        check("dropcnt_one", {16'b0, drop_cnt_o}, 32'd1);
`endif

        cam_vsync_i = 1'b1;
        tick();
        cam_vsync_i = 1'b0;
        check("ovf_before_clear", {31'b0, overflow_o}, 32'd1);
        tick();
        check("ovf_cleared", {31'b0, overflow_o}, 32'd0);
        auto_rdy = 1'b1;
        vcnt = 0;
        drain("drain5");
        repeat (3) tick();
        check("empty_after_drain", {31'b0, valid_o}, 32'd0);
`ifdef OV_PACKER_DROP_CNT_EN
        check("dropcnt_kept", {16'b0, drop_cnt_o}, 32'd1);
`endif

        auto_rdy = 1'b0;
        w = $urandom;
        latency("pre_reset", w);
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        send_line(q);
        exp_w.delete();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_valid", {31'b0, valid_o}, 32'd0);
        check("async_reset_data", data_o, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        w = $urandom;
        latency("post_reset", w);
        auto_rdy = 1'b1;
        vcnt = 0;
        drain("post_reset");
        repeat (4) tick();
        check("post_reset_empty", {31'b0, valid_o}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
